frame_sched: RTL and testbench

- Capture scheduler sitting between the camera pixel driver and the image-processing reader.
- Decides when the driver may capture and counts the pixels written per frame.
- Double-buffers the frame RAM in two banks: a complete, correctly sized frame is handed to the reader while the next frame fills the other bank.
- Flags short/long frames, dropped frames and a stalled camera.

---
 rtl/frame_sched.sv | 136 +++++++++++++
 tb/tb_frame_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sched.sv
// Capture scheduler for the camera front end: gates the pixel driver,
// counts pixel writes per frame and ping-pongs the two frame RAM banks
// between the writer and the image-processing reader.
module frame_sched #(
  parameter int unsigned AW        = 15,
  parameter int unsigned FRAME_PIX = 25344,
  parameter int unsigned TMO       = 2000000,
  parameter int unsigned DW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          single,
  input  logic          vsync,
  input  logic          wr_en,
  input  logic          rd_ack,
  output logic          cap_en,
  output logic          wr_bank,
  output logic          rd_bank,
  output logic          rd_valid,
  output logic [AW-1:0] pix_cnt,
  output logic [DW-1:0] frame_cnt,
  output logic [DW-1:0] drop_cnt,
  output logic          err_len,
  output logic          err_tmo
);

  localparam int unsigned WW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_ARM,
    S_CAPT,
    S_CHECK
  } state_t;

  state_t        state, state_nxt;
  logic          vsync_q;
  logic          one_shot;
  logic [WW-1:0] wd;

  logic vs_rise, vs_fall, vs_edge;
  logic wd_on, tmo_hit, good, busy, swap;

  // Frame-level decode shared by the FSM and the datapath
  always_comb begin
    vs_rise = vsync & ~vsync_q;
    vs_fall = ~vsync & vsync_q;
    vs_edge = vs_rise | vs_fall;
    wd_on   = (state == S_SYNC) || (state == S_ARM) || (state == S_CAPT);
    tmo_hit = wd_on && !vs_edge && (wd == WW'(TMO - 1));
    good    = (pix_cnt == AW'(FRAME_PIX));
    // an ack in the CHECK cycle frees the reader bank before the swap decision
    busy    = rd_valid & ~rd_ack;
    swap    = (state == S_CHECK) && good && !busy;
  end

  // Next-state decode and driver enable
  always_comb begin
    state_nxt = state;
    cap_en    = (state == S_ARM) || (state == S_CAPT);
    if (tmo_hit) begin
      state_nxt = run ? S_SYNC : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run || single) state_nxt = S_SYNC;
        S_SYNC: begin
          if (!run && !one_shot) state_nxt = S_IDLE;
          else if (vs_rise)      state_nxt = S_ARM;
        end
        S_ARM: begin
          if (!run && !one_shot) state_nxt = S_IDLE;
          else if (vs_fall)      state_nxt = S_CAPT;
        end
        S_CAPT:  if (vs_rise) state_nxt = S_CHECK;
        S_CHECK: state_nxt = run ? S_ARM : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register, VSYNC history, watchdog and one-shot request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      vsync_q  <= 1'b0;
      wd       <= '0;
      one_shot <= 1'b0;
    end else begin
      state   <= state_nxt;
      vsync_q <= vsync;
      if (!wd_on || (state_nxt != state) || vs_edge || tmo_hit) wd <= '0;
      else                                                   wd <= wd + 1'b1;
      if ((state == S_IDLE) && single)            one_shot <= 1'b1;
      else if (tmo_hit)                           one_shot <= 1'b0;
      else if ((state == S_CHECK) && !run)        one_shot <= 1'b0;
    end
  end

  // Pixel counting and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt <= '0;
      err_len <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      if ((state == S_ARM) && (state_nxt == S_CAPT)) pix_cnt <= '0;
      else if ((state == S_CAPT) && wr_en && (pix_cnt != '1)) pix_cnt <= pix_cnt + 1'b1;
      err_len <= (state == S_CHECK) && !good;
      err_tmo <= tmo_hit;
    end
  end

  // Bank ownership hand-off and frame statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b1;
      rd_valid  <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (swap) begin
        rd_bank   <= wr_bank;
        wr_bank   <= ~wr_bank;
        rd_valid  <= 1'b1;
        frame_cnt <= frame_cnt + 1'b1;
      end else if (rd_ack) begin
        rd_valid  <= 1'b0;
      end
      if ((state == S_CHECK) && good && busy && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched: a bank/counter model predicts the
// outcome of every frame as it is driven; a monitor pops the prediction
// when the DUT reports the frame result.
module tb_frame_sched;

  localparam int AW  = 6;
  localparam int DW  = 8;
  localparam int FP  = 16;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst, run, single, vsync, wr_en, rd_ack;
  logic          cap_en, wr_bank, rd_bank, rd_valid, err_len, err_tmo;
  logic [AW-1:0] pix_cnt;
  logic [DW-1:0] frame_cnt, drop_cnt;

  always #5 clk = ~clk;

  frame_sched #(.AW(AW), .FRAME_PIX(FP), .TMO(TMO), .DW(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .single(single), .vsync(vsync),
    .wr_en(wr_en), .rd_ack(rd_ack), .cap_en(cap_en), .wr_bank(wr_bank),
    .rd_bank(rd_bank), .rd_valid(rd_valid), .pix_cnt(pix_cnt),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .err_len(err_len),
    .err_tmo(err_tmo)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          el;
    logic          rb;
    logic          wb;
    logic          rv;
    logic [DW-1:0] fc;
    logic [DW-1:0] dc;
  } exp_t;

  exp_t sb[$];

  logic          m_wb, m_rb, m_rv;
  logic [DW-1:0] m_fc, m_dc;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_wb = 1'b0; m_rb = 1'b1; m_rv = 1'b0; m_fc = '0; m_dc = '0;
  endtask

  // Reset is asynchronous: outputs are checked before any clock edge.
  task automatic do_reset;
    rst = 1'b0;
    #1;
    check("rst_cap_en",    cap_en,    0);
    check("rst_wr_bank",   wr_bank,   0);
    check("rst_rd_bank",   rd_bank,   1);
    check("rst_rd_valid",  rd_valid,  0);
    check("rst_pix_cnt",   pix_cnt,   0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt",  drop_cnt,  0);
    check("rst_err_len",   err_len,   0);
    check("rst_err_tmo",   err_tmo,   0);
    model_reset();
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic push_frame(input int n, input bit ack_in_chk);
    exp_t e;
    bit good, busy;
    good = (n == FP);
    busy = m_rv && !ack_in_chk;
    if (good && !busy) begin
      m_rb = m_wb; m_wb = ~m_wb; m_rv = 1'b1; m_fc = m_fc + 1'b1;
    end else if (good) begin
      if (m_dc != '1) m_dc = m_dc + 1'b1;
    end else if (ack_in_chk) begin
      m_rv = 1'b0;
    end
    e.el = !good; e.rb = m_rb; e.wb = m_wb; e.rv = m_rv; e.fc = m_fc; e.dc = m_dc;
    sb.push_back(e);
  endtask

  // VSYNC low pulse then rising edge: start-of-frame blank
  task automatic blank;
    vsync = 1'b0; tick();
    vsync = 1'b1; tick(); tick(); tick();
  endtask

  // One camera frame of n pixel writes; edge_wr puts the last write on the
  // closing VSYNC edge, ack_in_chk pulses rd_ack during the CHECK cycle.
  task automatic send_frame(input int n, input bit edge_wr, input bit ack_in_chk);
    int cnt;
    push_frame(n, ack_in_chk);
    cnt = edge_wr ? n - 1 : n;
    vsync = 1'b0; tick();
    check("cap_en_capt", cap_en, 1);
    tick();
    for (int i = 0; i < cnt; i++) begin
      wr_en = 1'b1; tick();
    end
    wr_en = 1'b0; tick();
    check("pix_cnt_mid", pix_cnt, cnt);
    tick();
    if (edge_wr) wr_en = 1'b1;
    vsync = 1'b1; tick();
    wr_en = 1'b0;
    if (ack_in_chk) rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic do_ack;
    rd_ack = 1'b1; tick();
    rd_ack = 1'b0;
    m_rv = 1'b0;
    check("rd_valid_after_ack", rd_valid, 0);
    tick();
  endtask

  // Frame-result monitor
  logic [DW-1:0] last_fc, last_dc;
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      last_fc = '0;
      last_dc = '0;
    end else if (err_len || frame_cnt != last_fc || drop_cnt != last_dc) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_event", {29'd0, err_len, frame_cnt != last_fc, drop_cnt != last_dc}, 0);
      end else begin
        e = sb.pop_front();
        check("sb_err_len",   err_len,   e.el);
        check("sb_frame_cnt", frame_cnt, e.fc);
        check("sb_drop_cnt",  drop_cnt,  e.dc);
        check("sb_rd_bank",   rd_bank,   e.rb);
        check("sb_wr_bank",   wr_bank,   e.wb);
        check("sb_rd_valid",  rd_valid,  e.rv);
      end
      last_fc = frame_cnt;
      last_dc = drop_cnt;
    end
  end

  initial begin
    int lat;
    bit found;
    rst = 1'b1; run = 1'b0; single = 1'b0; vsync = 1'b0; wr_en = 1'b0; rd_ack = 1'b0;
    model_reset();
    #2;
    do_reset();

    // continuous capture with the reader keeping up
    run = 1'b1;
    blank();
    for (int f = 0; f < 3; f++) begin
      send_frame(FP, 1'b0, 1'b0);
      do_ack();
    end
    check("t1_frame_cnt", frame_cnt, 3);
    check("t1_drop_cnt",  drop_cnt,  0);

    // reader never releases: second good frame is dropped
    do_reset();
    blank();
    send_frame(FP, 1'b0, 1'b0);
    send_frame(FP, 1'b0, 1'b0);
    check("t2_drop_cnt",  drop_cnt,  1);
    check("t2_frame_cnt", frame_cnt, 1);
    check("t2_wr_bank",   wr_bank,   1);

    // short and long frames
    send_frame(FP - 1, 1'b0, 1'b0);
    send_frame(FP + 1, 1'b0, 1'b0);
    check("t3_frame_cnt", frame_cnt, 1);
    do_ack();

    // last write on the closing edge, then ack colliding with CHECK
    send_frame(FP, 1'b1, 1'b0);
    send_frame(FP, 1'b0, 1'b1);
    check("t5_drop_cnt", drop_cnt, 1);

    // single-shot capture
    run = 1'b0; tick(); tick();
    do_ack();
    single = 1'b1; tick();
    single = 1'b0;
    blank();
    send_frame(FP, 1'b0, 1'b0);
    check("t4_cap_en_idle", cap_en, 0);
    vsync = 1'b0; tick(); tick();
    check("t4_cap_en_noarm", cap_en, 0);
    for (int i = 0; i < FP; i++) begin
      wr_en = 1'b1; tick();
    end
    wr_en = 1'b0;
    vsync = 1'b1; tick(); tick(); tick();
    check("t4_frame_cnt_hold", frame_cnt, m_fc);
    check("t4_pix_cnt_hold",   pix_cnt,   FP);

    // watchdog in CAPT
    run = 1'b1; tick();
    blank();
    vsync = 1'b0;
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      wr_en = (i >= 2 && i <= 6);
      tick();
      if (err_tmo) begin found = 1'b1; lat = i; end
    end
    wr_en = 1'b0;
    check("tmo_latency",    lat,     TMO + 1);
    check("tmo_pix_frozen", pix_cnt, 5);
    check("tmo_cap_en",     cap_en,  0);
    tick();
    check("tmo_pulse",      err_tmo, 0);

    // asynchronous reset in the middle of a frame
    blank();
    vsync = 1'b0; tick(); tick();
    wr_en = 1'b1; tick(); tick();
    wr_en = 1'b0;
    check("pre_rst_pix_cnt", pix_cnt, 2);
    check("pre_rst_cap_en",  cap_en,  1);
    do_reset();

    tick(); tick();
    check("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
